// File: rtl/rename_stage_pkg.sv
// Shared types and widths for the rename slice of the pipeline.
package common;

  localparam int unsigned DEF_PHY_REG_NUM  = 64;
  localparam int unsigned DEF_ARCH_REG_NUM = 32;
  localparam int unsigned ROB_SIZE         = 16;
  localparam int unsigned PAYLOAD_W        = 32;

  localparam int unsigned PHY_ID_W  = $clog2(DEF_PHY_REG_NUM);
  localparam int unsigned ARCH_ID_W = $clog2(DEF_ARCH_REG_NUM);
  localparam int unsigned ROB_ID_W  = $clog2(ROB_SIZE);

  // Decoded op as presented by the decode stage.
  typedef struct packed {
    logic [ARCH_ID_W-1:0] rs1;
    logic [ARCH_ID_W-1:0] rs2;
    logic [ARCH_ID_W-1:0] rd;
    logic                 rs1_valid;
    logic                 rs2_valid;
    logic                 rd_valid;
    logic [PAYLOAD_W-1:0] payload;
  } decode_rename_op_t;

  // Renamed op handed to register read; rd_valid means a new phy was allocated.
  typedef struct packed {
    logic [PHY_ID_W-1:0]  rs1_phy;
    logic [PHY_ID_W-1:0]  rs2_phy;
    logic                 rs1_valid;
    logic                 rs2_valid;
    logic [ARCH_ID_W-1:0] rd;
    logic                 rd_valid;
    logic [PHY_ID_W-1:0]  new_phy_id;
    logic [PHY_ID_W-1:0]  old_phy_id;
    logic [ROB_ID_W-1:0]  rob_id;
    logic [PAYLOAD_W-1:0] payload;
  } rename_readreg_op_t;

  // ROB entry: enough to restore or release the mapping at commit/flush.
  typedef struct packed {
    logic [PHY_ID_W-1:0]  new_phy_id;
    logic [PHY_ID_W-1:0]  old_phy_id;
    logic [ARCH_ID_W-1:0] rd;
    logic                 rd_valid;
  } rob_item_t;

endpackage

// File: rtl/rename_bypass.sv
// Intra-group forwarding: a source (or rd) read sees the newest earlier
// in-group producer instead of the stale RAT entry; arch reg 0 reads phy 0.
module rename_bypass
  import common::*;
#(
  parameter int unsigned RENAME_WIDTH = 2
) (
  input  logic [ARCH_ID_W-1:0] arch_id    [0:RENAME_WIDTH-1][0:2],
  input  logic [RENAME_WIDTH-1:0] needs_dest,
  input  logic [PHY_ID_W-1:0]  new_phy    [0:RENAME_WIDTH-1],
  input  logic [PHY_ID_W-1:0]  rat_phy    [0:RENAME_WIDTH-1][0:2],
  output logic [PHY_ID_W-1:0]  src_phy    [0:RENAME_WIDTH-1][0:2]
);

  // Per slot and field: RAT value, overridden by later (closer) producers in order.
  always_comb begin
    for (int unsigned i = 0; i < RENAME_WIDTH; i++) begin
      for (int unsigned f = 0; f < 3; f++) begin
        src_phy[i][f] = rat_phy[i][f];
        for (int unsigned j = 0; j < i; j++) begin
          if (needs_dest[j] && (arch_id[j][2] == arch_id[i][f]))
            src_phy[i][f] = new_phy[j];
        end
        if (arch_id[i][f] == '0)
          src_phy[i][f] = '0;
      end
    end
  end

endmodule

// File: rtl/rename_stage.sv
// Rename stage: allocates physical registers for an all-or-nothing group,
// updates the RAT, pushes ROB entries and registers the renamed ops.
module rename_stage
  import common::*;
#(
  parameter int unsigned RENAME_WIDTH = 2,
  parameter int unsigned PHY_REG_NUM  = 64,
  parameter int unsigned ARCH_REG_NUM = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  decode_rename_op_t                 decode_rename_op            [0:RENAME_WIDTH-1],
  input  logic [RENAME_WIDTH-1:0]           decode_rename_op_valid,
  output logic                              rename_decode_pop,
  input  logic [$clog2(PHY_REG_NUM)-1:0]    rat_rename_new_phy_id       [0:RENAME_WIDTH-1],
  input  logic [RENAME_WIDTH-1:0]           rat_rename_new_phy_id_valid,
  output logic [$clog2(ARCH_REG_NUM)-1:0]   rename_rat_read_arch_id     [0:RENAME_WIDTH-1][0:2],
  input  logic [$clog2(PHY_REG_NUM)-1:0]    rat_rename_read_phy_id      [0:RENAME_WIDTH-1][0:2],
  output logic [$clog2(PHY_REG_NUM)-1:0]    rename_rat_phy_id           [0:RENAME_WIDTH-1],
  output logic [RENAME_WIDTH-1:0]           rename_rat_phy_id_valid,
  output logic [$clog2(ARCH_REG_NUM)-1:0]   rename_rat_arch_id          [0:RENAME_WIDTH-1],
  output logic                              rename_rat_map,
  input  logic [$clog2(ROB_SIZE):0]         rob_rename_free_space,
  input  logic [ROB_ID_W-1:0]               rob_rename_new_id           [0:RENAME_WIDTH-1],
  output logic [RENAME_WIDTH-1:0]           rename_rob_push,
  output rob_item_t                         rename_rob_data             [0:RENAME_WIDTH-1],
  output rename_readreg_op_t                rename_readreg_op           [0:RENAME_WIDTH-1],
  output logic [RENAME_WIDTH-1:0]           rename_readreg_op_valid,
  input  logic                              readreg_rename_stall,
  input  logic                              commit_flush
);

  logic [RENAME_WIDTH-1:0] needs_dest;
  logic [PHY_ID_W-1:0]     new_phy  [0:RENAME_WIDTH-1];
  logic [PHY_ID_W-1:0]     src_phy  [0:RENAME_WIDTH-1][0:2];
  rename_readreg_op_t      op_next  [0:RENAME_WIDTH-1];
  int unsigned             n_ops;
  int unsigned             n_dest;
  int unsigned             n_free;
  logic                    fire;

  // Classify slots, count resources and hand the k-th free phy to the k-th dest op.
  always_comb begin
    needs_dest = '0;
    n_ops      = 0;
    n_dest     = 0;
    n_free     = 0;
    for (int unsigned i = 0; i < RENAME_WIDTH; i++) begin
      needs_dest[i] = decode_rename_op_valid[i] && decode_rename_op[i].rd_valid &&
                      (decode_rename_op[i].rd != '0);
      new_phy[i] = '0;
      for (int unsigned k = 0; k < RENAME_WIDTH; k++) begin
        if (needs_dest[i] && (n_dest == k))
          new_phy[i] = rat_rename_new_phy_id[k];
      end
      if (decode_rename_op_valid[i])      n_ops++;
      if (needs_dest[i])                  n_dest++;
      if (rat_rename_new_phy_id_valid[i]) n_free++;
    end
  end

  // Group fires only when every resource is available and nothing blocks it.
  always_comb begin
    fire = !rst && (n_ops != 0) && (n_dest <= n_free) &&
           (n_ops <= 32'(rob_rename_free_space)) &&
           !readreg_rename_stall && !commit_flush;
  end

  rename_bypass #(
    .RENAME_WIDTH (RENAME_WIDTH)
  ) u_bypass (
    .arch_id    (rename_rat_read_arch_id),
    .needs_dest (needs_dest),
    .new_phy    (new_phy),
    .rat_phy    (rat_rename_read_phy_id),
    .src_phy    (src_phy)
  );

  // RAT lookups, RAT map, ROB push and next-op build; handshakes gated by fire.
  always_comb begin
    rename_decode_pop       = fire;
    rename_rat_map          = fire;
    rename_rob_push         = fire ? decode_rename_op_valid : '0;
    rename_rat_phy_id_valid = rst ? '0 : needs_dest;
    for (int unsigned i = 0; i < RENAME_WIDTH; i++) begin
      rename_rat_read_arch_id[i][0] = decode_rename_op[i].rs1;
      rename_rat_read_arch_id[i][1] = decode_rename_op[i].rs2;
      rename_rat_read_arch_id[i][2] = decode_rename_op[i].rd;
      rename_rat_phy_id[i]          = new_phy[i];
      rename_rat_arch_id[i]         = decode_rename_op[i].rd;

      op_next[i].rs1_phy    = src_phy[i][0];
      op_next[i].rs2_phy    = src_phy[i][1];
      op_next[i].rs1_valid  = decode_rename_op[i].rs1_valid;
      op_next[i].rs2_valid  = decode_rename_op[i].rs2_valid;
      op_next[i].rd         = decode_rename_op[i].rd;
      op_next[i].rd_valid   = needs_dest[i];
      op_next[i].new_phy_id = new_phy[i];
      op_next[i].old_phy_id = needs_dest[i] ? src_phy[i][2] : '0;
      op_next[i].rob_id     = rob_rename_new_id[i];
      op_next[i].payload    = decode_rename_op[i].payload;

      rename_rob_data[i].new_phy_id = op_next[i].new_phy_id;
      rename_rob_data[i].old_phy_id = op_next[i].old_phy_id;
      rename_rob_data[i].rd         = op_next[i].rd;
      rename_rob_data[i].rd_valid   = needs_dest[i];
    end
  end

  // Output register: load on fire, hold under stall, flush/idle clears valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      rename_readreg_op_valid <= '0;
      for (int unsigned i = 0; i < RENAME_WIDTH; i++)
        rename_readreg_op[i] <= '0;
    end else if (fire) begin
      rename_readreg_op_valid <= decode_rename_op_valid;
      rename_readreg_op       <= op_next;
    end else if (readreg_rename_stall && !commit_flush) begin
      rename_readreg_op_valid <= rename_readreg_op_valid;
    end else begin
      rename_readreg_op_valid <= '0;
    end
  end

endmodule
